car_draw_ctrl: RTL and testbench
================================

// Module: car_draw_ctrl
// PURPOSE
//  Per-frame sequencer for the player car sprite. On each frame tick it erases the car at its old position,
//  applies left/right movement, then drives the upstream sprite drawer (enable, origin) while forwarding its
//  pixel stream to the VGA adapter (x, y, colour, plot). Sits between the game/input logic and the VGA adapter.
// PARAMETERS
//  SPRITE_W   21      sprite width in pixels
//  SPRITE_H   30      sprite height in pixels
//  X_INIT     8'd33   car left edge after reset
//  Y_POS      7'd88   car top edge (fixed)
//  X_MIN      8'd30   smallest legal left edge
//  X_MAX      8'd109  largest legal left edge
//  STEP       8'd4    pixels moved per frame
//  BG_COLOUR  3'b000  colour written during erase
//  TRANSP     3'b111  sprite colour not plotted (transparent)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  frame_tick  in   1  one-cycle pulse per video frame
//  move_left   in   1  level: steer left this frame
//  move_right  in   1  level: steer right this frame
//  spr_en      out  1  enable to sprite drawer; low holds drawer counters at 0
//  spr_x       out  8  sprite origin x to drawer (current car x)
//  spr_y       out  7  sprite origin y to drawer (= Y_POS)
//  spr_px_x    in   8  drawer pixel x (origin + column counter)
//  spr_px_y    in   7  drawer pixel y (origin + row counter)
//  spr_colour  in   3  drawer ROM colour; valid one cycle after its pixel address
//  vga_x       out  8  pixel x to VGA adapter
//  vga_y       out  7  pixel y to VGA adapter
//  vga_colour  out  3  pixel colour to VGA adapter
//  plot        out  1  write strobe to VGA adapter
//  busy        out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, car_x=X_INIT, pending=1, all counters 0; spr_en=0, plot=0, busy=0,
//   vga_x=0, vga_y=0, vga_colour=0. Reset mid-operation aborts the frame; spr_en=0 makes the drawer restart.
//  pending: set by frame_tick in any state, cleared on IDLE->ERASE; ticks while pending=1 are absorbed.
//  States:
//   IDLE   : pending=1 -> ERASE (next cycle).
//   ERASE  : col 0..SPRITE_W-1 inner, row 0..SPRITE_H-1 outer; each cycle plot=1, vga_x=car_x+col,
//            vga_y=Y_POS+row, vga_colour=BG_COLOUR. Exactly SPRITE_W*SPRITE_H (630) cycles, then UPDATE.
//   UPDATE : one cycle, plot=0. left&!right: car_x = (car_x>=X_MIN+STEP) ? car_x-STEP : X_MIN.
//            right&!left: car_x = (car_x+STEP<=X_MAX) ? car_x+STEP : X_MAX. Both or neither: unchanged.
//            Compare in 9 bits (no 8-bit wrap). Inputs sampled only in this cycle. -> DRAW.
//   DRAW   : spr_en=1 for SPRITE_W*SPRITE_H+1 (631) cycles; spr_x=car_x, spr_y=Y_POS stable throughout.
//            spr_px_x/y registered one cycle to align with spr_colour (1-cycle ROM latency).
//            From DRAW cycle 2 to 631: vga_x/y = registered px, vga_colour=spr_colour,
//            plot = (spr_colour != TRANSP). DRAW cycle 1: plot=0. After cycle 631 -> IDLE, spr_en=0.
//  Frame cost 630+1+631 = 1262 cycles; pending tick honoured immediately on return to IDLE.
//  plot=0 in IDLE and UPDATE; vga_* hold last value when plot=0.
// TESTING
//  1. Release reset, no tick -> ERASE starts 1 cycle later; 630 plots of colour 0 at x 33..53, y 88..117.
//  2. Continue (1) with stub drawer (ROM = addr[2:0]) -> spr_en high 631 cycles, spr_x=33;
//     first plot in DRAW cycle 2 at (33,88) colour 0; addr 7 (colour 7) not plotted; busy low afterwards.
//  3. car_x=33, move_left=1, tick -> UPDATE clamps car_x=30; next tick again -> stays 30.
//  4. car_x=107, move_right=1, tick -> car_x=109 (clamped); move_left=move_right=1 -> unchanged.
//  5. Two ticks during ERASE -> exactly one extra frame runs; third frame only after a new tick.
//  6. Assert reset during DRAW cycle 300 -> plot/spr_en/busy 0 at once; car_x=X_INIT; new frame after release.

Source files
------------

// File: rtl/car_draw_ctrl.sv
// Per-frame sequencer for the player car sprite: erase old position, apply steering,
// then run the sprite drawer and forward its pixel stream to the VGA adapter.
module car_draw_ctrl #(
    parameter int          SPRITE_W  = 21,
    parameter int          SPRITE_H  = 30,
    parameter logic [7:0]  X_INIT    = 8'd33,
    parameter logic [6:0]  Y_POS     = 7'd88,
    parameter logic [7:0]  X_MIN     = 8'd30,
    parameter logic [7:0]  X_MAX     = 8'd109,
    parameter logic [7:0]  STEP      = 8'd4,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter logic [2:0]  TRANSP    = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    output logic       spr_en,
    output logic [7:0] spr_x,
    output logic [6:0] spr_y,
    input  logic [7:0] spr_px_x,
    input  logic [6:0] spr_px_y,
    input  logic [2:0] spr_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int DW = $clog2(SPRITE_W * SPRITE_H + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(SPRITE_H - 1);
    localparam logic [DW-1:0] DRAW_LAST = DW'(SPRITE_W * SPRITE_H);

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        UPDATE,
        DRAW
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    car_x_q, car_x_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] draw_cnt_q, draw_cnt_d;
    logic [7:0]    px_x_q;
    logic [6:0]    px_y_q;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [2:0]    vga_colour_q, vga_colour_d;

    // Clamp comparisons are done in 9 bits so car_x +/- STEP never wraps.
    logic [8:0] car_x_9;
    logic [8:0] left_limit_9;
    logic [8:0] right_sum_9;

    assign car_x_9      = {1'b0, car_x_q};
    assign left_limit_9 = {1'b0, X_MIN} + {1'b0, STEP};
    assign right_sum_9  = car_x_9 + {1'b0, STEP};

    always_comb begin
        state_d      = state_q;
        car_x_d      = car_x_q;
        pending_d    = pending_q;
        col_d        = col_q;
        row_d        = row_q;
        draw_cnt_d   = draw_cnt_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        spr_en       = 1'b0;
        plot         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = ERASE;
                    pending_d = 1'b0;
                end
            end
            ERASE: begin
                plot         = 1'b1;
                vga_x_d      = car_x_q + 8'(col_q);
                vga_y_d      = Y_POS + 7'(row_q);
                vga_colour_d = BG_COLOUR;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = UPDATE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            UPDATE: begin
                if (move_left && !move_right) begin
                    car_x_d = (car_x_9 >= left_limit_9) ? car_x_q - STEP : X_MIN;
                end else if (move_right && !move_left) begin
                    car_x_d = (right_sum_9 <= {1'b0, X_MAX}) ? car_x_q + STEP : X_MAX;
                end
                draw_cnt_d = '0;
                state_d    = DRAW;
            end
            DRAW: begin
                spr_en = 1'b1;
                // First draw cycle has no ROM data yet; afterwards pixels lag the address by one.
                if (draw_cnt_q != '0) begin
                    vga_x_d      = px_x_q;
                    vga_y_d      = px_y_q;
                    vga_colour_d = spr_colour;
                    plot         = (spr_colour != TRANSP);
                end
                if (draw_cnt_q == DRAW_LAST) begin
                    draw_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    draw_cnt_d = draw_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_tick) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            car_x_q      <= X_INIT;
            pending_q    <= 1'b1;
            col_q        <= '0;
            row_q        <= '0;
            draw_cnt_q   <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            car_x_q      <= car_x_d;
            pending_q    <= pending_d;
            col_q        <= col_d;
            row_q        <= row_d;
            draw_cnt_q   <= draw_cnt_d;
            px_x_q       <= spr_px_x;
            px_y_q       <= spr_px_y;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign vga_x      = vga_x_d;
    assign vga_y      = vga_y_d;
    assign vga_colour = vga_colour_d;
    assign spr_x      = car_x_q;
    assign spr_y      = Y_POS;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_car_draw_ctrl.sv
// Testbench for car_draw_ctrl: stub sprite drawer (ROM colour = addr[2:0]) plus a
// scoreboard of expected VGA plots and a table of steering vectors.
module tb_car_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       spr_en;
    logic [7:0] spr_x;
    logic [6:0] spr_y;
    logic [7:0] spr_px_x;
    logic [6:0] spr_px_y;
    logic [2:0] spr_colour = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;

    car_draw_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_px_x(spr_px_x), .spr_px_y(spr_px_y), .spr_colour(spr_colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub drawer: counters held at 0 while spr_en is low, ROM data one cycle late.
    logic [4:0] d_col = 5'd0;
    logic [4:0] d_row = 5'd0;
    logic [9:0] d_addr;
    assign d_addr   = 10'(d_row) * 10'd21 + 10'(d_col);
    assign spr_px_x = spr_x + 8'(d_col);
    assign spr_px_y = spr_y + 7'(d_row);

    always @(posedge clk) begin
        spr_colour <= d_addr[2:0];
        if (!spr_en) begin
            d_col <= 5'd0;
            d_row <= 5'd0;
        end else if (d_col == 5'd20) begin
            d_col <= 5'd0;
            d_row <= d_row + 5'd1;
        end else begin
            d_col <= d_col + 5'd1;
        end
    end

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic       left;
        logic       right;
        logic [7:0] exp_x;
    } vec_t;

    pix_t       sb[$];
    pix_t       exp_pix;
    vec_t       vecs[$];
    int         checks = 0;
    int         passes = 0;
    int         en_count = 0;
    logic [7:0] exp_spr_x = 8'd33;
    logic [7:0] model_x = 8'd33;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic pushFrame(input logic [7:0] erase_x, input logic [7:0] draw_x);
        pix_t p;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 21; c++) begin
                p.x = erase_x + 8'(c);
                p.y = 7'(88 + r);
                p.c = 3'd0;
                sb.push_back(p);
            end
        end
        for (int a = 0; a < 630; a++) begin
            if ((a % 8) != 7) begin
                p.x = draw_x + 8'(a % 21);
                p.y = 7'(88 + a / 21);
                p.c = 3'(a % 8);
                sb.push_back(p);
            end
        end
    endtask

    // Scoreboard consumer: every plot must match the next expected pixel.
    always @(negedge clk) begin
        if (reset) begin
            if (spr_en) begin
                en_count++;
                checkOutput("spr_x", int'(spr_x), int'(exp_spr_x));
                checkOutput("spr_y", int'(spr_y), 88);
            end
            if (plot) begin
                if (sb.size() == 0) begin
                    checkOutput("plot_with_empty_scoreboard", sb.size(), 1);
                end else begin
                    exp_pix = sb.pop_front();
                    checkOutput("vga_x", int'(vga_x), int'(exp_pix.x));
                    checkOutput("vga_y", int'(vga_y), int'(exp_pix.y));
                    checkOutput("vga_colour", int'(vga_colour), int'(exp_pix.c));
                end
            end
        end
    end

    task automatic waitBusyLow(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput({name, "_timeout"}, int'(busy), 0);
    endtask

    task automatic finishFrame(input logic [7:0] draw_x, input int exp_en);
        waitBusyLow("frame_end");
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("spr_en_cycles", en_count, exp_en);
        checkOutput("spr_en_low_idle", int'(spr_en), 0);
        checkOutput("hold_vga_x", int'(vga_x), int'(draw_x) + 20);
        checkOutput("hold_vga_y", int'(vga_y), 117);
        checkOutput("hold_vga_colour", int'(vga_colour), 5);
    endtask

    task automatic pulseTick();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic [7:0] exp_x);
        pushFrame(model_x, exp_x);
        exp_spr_x = exp_x;
        en_count  = 0;
        move_left  = l;
        move_right = r;
        pulseTick();
        @(posedge clk);
        #1 checkOutput("busy_after_tick", int'(busy), 1);
        finishFrame(exp_x, 631);
        model_x = exp_x;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        vec_t v;
        v = '{1'b1, 1'b0, 8'd30};  vecs.push_back(v);
        v = '{1'b1, 1'b0, 8'd30};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 8'd34};  vecs.push_back(v);
        v = '{1'b1, 1'b1, 8'd34};  vecs.push_back(v);
        v = '{1'b0, 1'b0, 8'd34};  vecs.push_back(v);
        for (int k = 1; k <= 18; k++) begin
            v = '{1'b0, 1'b1, 8'(34 + 4 * k)};
            vecs.push_back(v);
        end
        v = '{1'b0, 1'b1, 8'd109}; vecs.push_back(v);
        v = '{1'b0, 1'b1, 8'd109}; vecs.push_back(v);
        v = '{1'b1, 1'b1, 8'd109}; vecs.push_back(v);
        v = '{1'b1, 1'b0, 8'd105}; vecs.push_back(v);

        repeat (3) @(negedge clk);
        checkOutput("rst_spr_en", int'(spr_en), 0);
        checkOutput("rst_plot", int'(plot), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_vga_x", int'(vga_x), 0);
        checkOutput("rst_vga_y", int'(vga_y), 0);
        checkOutput("rst_vga_colour", int'(vga_colour), 0);

        // Pending is set out of reset, so a frame at X_INIT runs without a tick.
        pushFrame(8'd33, 8'd33);
        en_count = 0;
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("idle_after_release", int'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("erase_busy", int'(busy), 1);
        checkOutput("erase_first_plot", int'(plot), 1);
        checkOutput("erase_first_x", int'(vga_x), 33);
        checkOutput("erase_first_y", int'(vga_y), 88);
        finishFrame(8'd33, 631);

        foreach (vecs[i]) applyStimulus(vecs[i].left, vecs[i].right, vecs[i].exp_x);

        // Two ticks during ERASE give exactly one extra frame.
        pushFrame(model_x, model_x);
        pushFrame(model_x, model_x);
        exp_spr_x = model_x;
        en_count  = 0;
        move_left  = 1'b0;
        move_right = 1'b0;
        pulseTick();
        repeat (20) @(posedge clk);
        pulseTick();
        repeat (20) @(posedge clk);
        pulseTick();
        @(negedge clk);
        waitBusyLow("first_of_two");
        checkOutput("sb_second_frame_left", sb.size(), 630 + 552);
        @(posedge clk);
        #1 checkOutput("pending_restart", int'(busy), 1);
        finishFrame(model_x, 1262);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checkOutput("no_third_frame", int'(busy), 0);
        end

        // Reset in DRAW cycle 300 aborts the frame and restores X_INIT.
        pushFrame(model_x, model_x);
        exp_spr_x = model_x;
        pulseTick();
        n = 0;
        while (!spr_en && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!spr_en) checkOutput("draw_start_timeout", int'(spr_en), 1);
        repeat (299) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_plot", int'(plot), 0);
        checkOutput("abort_spr_en", int'(spr_en), 0);
        checkOutput("abort_busy", int'(busy), 0);
        sb.delete();
        model_x   = 8'd33;
        exp_spr_x = 8'd33;
        pushFrame(8'd33, 8'd33);
        en_count = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("restart_busy", int'(busy), 1);
        finishFrame(8'd33, 631);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
